bcd_serial_subtractor: RTL

- Multi-digit BCD subtractor; the inverse operation of the team's BCD ripple-carry adder path.
- Computes |A − B| and a sign flag, one BCD digit per clock, least significant digit first.
- A single 4-bit digit adder is reused every cycle, fed with A, the nine's complement of B, and the carry from the previous digit (ten's complement).
- Sits behind the digit-entry logic and in front of the seven-segment display path.

---
 rtl/bcd_serial_subtractor.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial BCD subtractor producing |A - B| and a
// sign flag. One shared 4-bit digit adder is used every cycle: in SUB it adds
// A, the nine's complement of B and the running carry (ten's complement
// subtraction). In FIX it re-complements a negative result in place.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; operands captured and range-checked on start
// S_SUB  | one digit of A + (9 - B) + carry per cycle, LSD first
// S_FIX  | A < B: ten's complement of the stored result, one digit per cycle
// S_DONE | result valid on diff_bcd, done pulses for this single cycle
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff_bcd,
  output logic                  negative,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W-1:0]    r_q,     r_d;
  logic [W-1:0]    diff_q,  diff_d;
  logic            neg_q,   neg_d;
  logic            inv_q,   inv_d;

  logic [3:0]      a_dig, b_dig, r_dig;
  logic [3:0]      add_x, add_y;
  logic [4:0]      dsum;
  logic            dcarry;
  logic [3:0]      dres;
  logic [W-1:0]    r_wr;
  logic            in_bad;
  logic            last_dig;

  // Select the operand and result digits addressed by the digit index.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    r_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
        r_dig = r_q[4*i +: 4];
      end
    end
  end

  // Shared digit adder: x + (9 - y) + carry with decimal correction.
  // SUB feeds A and B; FIX feeds 0 and the stored result digit.
  always_comb begin
    add_x = 4'd0;
    add_y = r_dig;
    if (state_q == S_SUB) begin
      add_x = a_dig;
      add_y = b_dig;
    end
    // Inputs are valid BCD here, so the sum is at most 9 + 9 + 1 = 19.
    dsum   = {1'b0, add_x} + {1'b0, 4'd9 - add_y} + {4'd0, carry_q};
    dcarry = (dsum >= 5'd10);
    dres   = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];
  end

  // Result register image with the current digit overwritten by the adder.
  always_comb begin
    r_wr = r_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        r_wr[4*i +: 4] = dres;
      end
    end
  end

  // Flag any non-BCD digit in either raw operand.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_bcd[4*i +: 4] > 4'd9) || (b_bcd[4*i +: 4] > 4'd9)) begin
        in_bad = 1'b1;
      end
    end
  end

  assign last_dig = (idx_q == IW'(DIGITS - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    diff_d  = diff_q;
    neg_d   = neg_q;
    inv_d   = inv_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a_bcd;
          b_d   = b_bcd;
          r_d   = '0;
          neg_d = 1'b0;
          inv_d = 1'b0;
          idx_d = '0;
          if (in_bad) begin
            // Non-BCD operands never reach the adder; report and finish.
            inv_d   = 1'b1;
            diff_d  = '0;
            carry_d = 1'b0;
            state_d = S_DONE;
          end else begin
            // Carry-in of 1 turns the nine's complement into ten's complement.
            carry_d = 1'b1;
            state_d = S_SUB;
          end
        end
      end

      S_SUB: begin
        r_d     = r_wr;
        carry_d = dcarry;
        idx_d   = idx_q + IW'(1);
        if (last_dig) begin
          idx_d = '0;
          if (dcarry) begin
            // Final carry out means A >= B; equal operands land here as +0.
            diff_d  = r_wr;
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            // No carry out: r holds the ten's complement of B - A.
            neg_d   = 1'b1;
            carry_d = 1'b1;
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        r_d     = r_wr;
        carry_d = dcarry;
        idx_d   = idx_q + IW'(1);
        if (last_dig) begin
          idx_d   = '0;
          diff_d  = r_wr;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      diff_q  <= '0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      diff_q  <= diff_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
    end
  end

  assign busy     = (state_q == S_SUB) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign diff_bcd = diff_q;
  assign negative = neg_q;
  assign invalid  = inv_q;

endmodule
